// File: rtl/rs_syndrome_calc_pkg.sv
// Shared types and constant helpers for the Reed-Solomon syndrome calculator.
package rs_syndrome_pkg;

  // Framing FSM states: waiting for a start symbol, accumulating, holding a result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // alpha^j in GF(2^m) with alpha = x, reduced by the generator polynomial.
  // Evaluated at elaboration time to build the constant multipliers.
  function automatic int unsigned gf_alpha_pow(input int unsigned j,
                                               input int unsigned m,
                                               input int unsigned poly);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < j; i++) begin
      v = v << 1;
      if (((v >> m) & 1) != 0) v = v ^ poly;
    end
    return v;
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_gf_mult_const.sv
// Combinational multiply of a GF(2^m) element by the constant alpha^POWER.
module gf_mult_const
  import rs_syndrome_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 4,
  parameter int unsigned PRIM_POLY   = 5'h13,
  parameter int unsigned POWER       = 1
) (
  input  logic [WORD_LENGTH-1:0] a_i,
  output logic [WORD_LENGTH-1:0] y_o
);

  localparam int unsigned CONST_VAL = gf_alpha_pow(POWER, WORD_LENGTH, PRIM_POLY);
  localparam logic [WORD_LENGTH-1:0] CONST_W  = CONST_VAL[WORD_LENGTH-1:0];
  localparam logic [WORD_LENGTH-1:0] POLY_LOW = PRIM_POLY[WORD_LENGTH-1:0];

  // Shift-and-xor product; each shift is a multiply by x with modular reduction.
  function automatic logic [WORD_LENGTH-1:0] mul_const(input logic [WORD_LENGTH-1:0] a);
    logic [WORD_LENGTH-1:0] acc;
    logic [WORD_LENGTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(WORD_LENGTH); i++) begin
      if (CONST_W[i]) acc = acc ^ sh;
      sh = {sh[WORD_LENGTH-2:0], 1'b0} ^ (sh[WORD_LENGTH-1] ? POLY_LOW : '0);
    end
    return acc;
  endfunction

  // Pure combinational product.
  always_comb begin
    y_o = mul_const(a_i);
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: Horner evaluation of r(alpha^j), j=1..N-K,
// with codeword framing checks and a valid/ready output hold stage.
// Handshake: an input symbol is consumed on a rising edge where i_valid && o_in_ready;
// a result is consumed on a rising edge where o_valid && i_ready, and until then
// o_valid, o_syndromes and o_error stay stable.
module rs_syndrome_calc
  import rs_syndrome_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 4,
  parameter int unsigned N           = 15,
  parameter int unsigned K           = 11,
  parameter int unsigned PRIM_POLY   = 5'h13
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start_codeword,
  input  logic                             i_end_codeword,
  input  logic                             i_valid,
  input  logic [WORD_LENGTH-1:0]           i_symbol,
  input  logic                             i_ready,
  output logic                             o_in_ready,
  output logic                             o_valid,
  output logic [(N-K)*WORD_LENGTH-1:0]     o_syndromes,
  output logic                             o_error,
  output logic                             o_frame_error
);

  localparam int unsigned T2 = N - K;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          count_inc;
  logic                   frame_err_q, frame_err_d;
  logic                   accept;
  logic                   load_syn;
  logic                   upd_syn;
  logic [WORD_LENGTH-1:0] syn_q [T2];
  logic [WORD_LENGTH-1:0] syn_d [T2];
  logic [WORD_LENGTH-1:0] prod  [T2];
  logic                   any_nonzero;

  assign accept    = i_valid && o_in_ready;
  assign count_inc = count_q + 1'b1;

  // One constant multiplier per syndrome: S_j * alpha^j.
  for (genvar j = 0; j < int'(T2); j++) begin : g_syn
    gf_mult_const #(
      .WORD_LENGTH(WORD_LENGTH),
      .PRIM_POLY  (PRIM_POLY),
      .POWER      (j + 1)
    ) u_mul (
      .a_i(syn_q[j]),
      .y_o(prod[j])
    );
    assign o_syndromes[j*WORD_LENGTH +: WORD_LENGTH] = syn_q[j];
  end

  // State, counter, syndrome and frame-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      for (int j = 0; j < int'(T2); j++) syn_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      for (int j = 0; j < int'(T2); j++) syn_q[j] <= syn_d[j];
    end
  end

  // Next-state and datapath control; count stops at N so it never wraps.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_syn    = 1'b0;
    upd_syn     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_start_codeword && !i_end_codeword) begin
            load_syn = 1'b1;
            count_d  = CW'(1);
            state_d  = ST_ACCUM;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (i_start_codeword) begin
            // Unexpected start: flag it and treat this symbol as a fresh codeword.
            frame_err_d = 1'b1;
            if (!i_end_codeword) begin
              load_syn = 1'b1;
              count_d  = CW'(1);
              state_d  = ST_ACCUM;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else if (i_end_codeword) begin
            upd_syn = 1'b1;
            if (count_inc == N_C) begin
              count_d = count_inc;
              state_d = ST_HOLD;
            end else begin
              frame_err_d = 1'b1;
              count_d     = '0;
              state_d     = ST_IDLE;
            end
          end else begin
            upd_syn = 1'b1;
            if (count_inc == N_C) begin
              frame_err_d = 1'b1;
              count_d     = '0;
              state_d     = ST_IDLE;
            end else begin
              count_d = count_inc;
            end
          end
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Syndrome next values: load first symbol, or Horner step S*alpha^j ^ symbol.
  always_comb begin
    for (int j = 0; j < int'(T2); j++) begin
      syn_d[j] = syn_q[j];
      if (load_syn)     syn_d[j] = i_symbol;
      else if (upd_syn) syn_d[j] = prod[j] ^ i_symbol;
    end
  end

  // Outputs; all forced low while rst is asserted.
  always_comb begin
    any_nonzero = 1'b0;
    for (int j = 0; j < int'(T2); j++) any_nonzero = any_nonzero | (|syn_q[j]);
    o_in_ready    = !rst && (state_q != ST_HOLD);
    o_valid       = !rst && (state_q == ST_HOLD);
    o_error       = o_valid && any_nonzero;
    o_frame_error = !rst && frame_err_q;
  end

endmodule

// File: doc/rs_syndrome_calc.md
RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 4, symbol width m (GF(2^m)).
REQ-002 SHALL have parameter N, default 15, codeword length in symbols.
REQ-003 SHALL have parameter K, default 11, message length; 2T = N-K syndromes.
REQ-004 SHALL have parameter PRIM_POLY, default 5'h13 (x^4+x+1), field generator polynomial.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port i_start_codeword, input, 1, first symbol of a received codeword.
REQ-008 SHALL have port i_end_codeword, input, 1, last symbol of a received codeword.
REQ-009 SHALL have port i_valid, input, 1, i_symbol and framing flags valid.
REQ-010 SHALL have port i_symbol, input, WORD_LENGTH, received symbol, highest-degree coefficient first.
REQ-011 SHALL have port i_ready, input, 1, downstream accepts o_syndromes.
REQ-012 SHALL have port o_in_ready, output, 1, block accepts input this cycle.
REQ-013 SHALL have port o_valid, output, 1, o_syndromes/o_error valid.
REQ-014 SHALL have port o_syndromes, output, (N-K)*WORD_LENGTH, S_1 in LSBs through S_(N-K) in MSBs.
REQ-015 SHALL have port o_error, output, 1, at least one syndrome nonzero.
REQ-016 SHALL have port o_frame_error, output, 1, one-cycle pulse on framing violation.

Function
REQ-017 SHALL compute S_j = r(alpha^j), j = 1..N-K, alpha = 2 (primitive element), via Horner: S_j <= S_j*alpha^j XOR i_symbol per accepted symbol.
REQ-018 SHALL accept a symbol only when i_valid && o_in_ready; otherwise ignore all inputs.
REQ-019 SHALL implement FSM IDLE, ACCUM, HOLD; o_in_ready = 1 in IDLE/ACCUM, 0 in HOLD.
REQ-020 IDLE: accepted symbol with i_start_codeword && !i_end_codeword SHALL load S_j = i_symbol, set count = 1, go to ACCUM.
REQ-021 IDLE: accepted symbol without i_start_codeword, or with start and end together, SHALL be dropped, pulse o_frame_error, stay IDLE.
REQ-022 ACCUM: accepted symbol without flags SHALL update S_j, increment count; if count reaches N without end flag, pulse o_frame_error, go IDLE.
REQ-023 ACCUM: accepted symbol with i_end_codeword SHALL update S_j; if it is symbol N, go HOLD; else pulse o_frame_error, go IDLE.
REQ-024 ACCUM: accepted symbol with i_start_codeword SHALL pulse o_frame_error and restart per REQ-020 with that symbol.
REQ-025 Latency: o_valid SHALL assert the cycle after the end symbol is accepted.
REQ-026 HOLD: o_valid = 1, o_syndromes and o_error stable until i_ready; on o_valid && i_ready go IDLE, o_valid = 0 next cycle.
REQ-027 o_error SHALL equal OR-reduction of all syndromes while o_valid, else 0.
REQ-028 count SHALL be clog2(N+1) bits, never wrap; GF arithmetic SHALL be carry-free modulo PRIM_POLY.

Reset
REQ-029 rst SHALL force state IDLE, count 0, syndromes 0, o_valid 0, o_error 0, o_frame_error 0, o_in_ready 0 while asserted.
REQ-030 o_in_ready SHALL be 1 the first cycle after rst deasserts; rst mid-codeword or in HOLD SHALL discard the partial/pending result with no o_valid or o_frame_error.

Structure
REQ-031 Package rs_syndrome_pkg SHALL hold the state enum and constant function computing alpha^j for PRIM_POLY.
REQ-032 Sub-module gf_mult_const (constant GF(2^m) multiplier by alpha^j) SHALL be instantiated N-K times.

Verification
REQ-033 All-zero 15-symbol codeword -> o_valid after end, o_syndromes all 0, o_error 0.
REQ-034 14 zeros then 1 -> S_1..S_4 = 1,1,1,1, o_error 1.
REQ-035 13 zeros, 1, 0 -> S_1..S_4 = 2,4,8,3, o_error 1.
REQ-036 End flag on 10th symbol -> o_frame_error one cycle, no o_valid, o_in_ready stays 1.
REQ-037 i_ready low 5 cycles in HOLD with i_valid toggling -> o_valid and o_syndromes stable, o_in_ready 0, inputs ignored; i_ready high -> IDLE next cycle.
REQ-038 rst asserted after 7 symbols -> all outputs 0; following valid codeword computes correctly.
